// File: rtl/inst_mem_arbiter.sv
// inst_mem_arbiter
// Two-master arbiter in front of the single-port 8K x 32 instruction RAM.
//   m0 : instruction-fetch port, read-only, fixed priority.
//   m1 : loader/debug port, read/write. After MAX_RUN back-to-back m0 grants
//        while m1 waits, m1 wins the next contested cycle.
// One access is issued per cycle. Read data returns exactly one cycle after
// issue and is flagged on the issuing master's readdatavalid.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   hold                  blocks new grants and drops mem_clken
//   m0_*                  fetch port (address/read/waitrequest/readdata/valid)
//   m1_*                  loader port (address/read/write/writedata/byteenable,
//                         waitrequest/readdata/valid)
//   mem_*                 RAM side (address/chipselect/write/writedata/
//                         byteenable/clken out, readdata in)
module inst_mem_arbiter #(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BE_W    = 4,
    parameter int unsigned MAX_RUN = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hold,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic [BE_W-1:0]   m1_byteenable,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    // run counter is sized for the full legal MAX_RUN range (1..255)
    localparam int unsigned RUN_W = 8;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_RUN);

    logic             req0;
    logic             req1;
    logic             m1_is_write;
    logic             gnt0;
    logic             gnt1;
    logic             issue_read;
    logic [RUN_W-1:0] run_cnt;
    logic             rd_pend;
    logic             rd_owner;

    // request decode; read+write together is treated as a write
    assign req0        = m0_read;
    assign req1        = m1_read | m1_write;
    assign m1_is_write = m1_write;

    // grant decision: m0 priority, m1 wins once the run limit is reached
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n && !hold) begin
            if (req0 && req1) begin
                if (run_cnt == RUN_MAX) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign m0_waitrequest = ~gnt0;
    assign m1_waitrequest = ~gnt1;

    // RAM command mux; idle defaults park on the m0 address with all lanes on
    always_comb begin
        mem_address    = m0_address;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        mem_byteenable = '1;
        if (gnt1) begin
            mem_address = m1_address;
            mem_write   = m1_is_write;
            if (m1_is_write) begin
                mem_writedata  = m1_writedata;
                mem_byteenable = m1_byteenable;
            end
        end
    end

    assign mem_chipselect = gnt0 | gnt1;
    assign mem_clken      = ~hold;

    assign issue_read = gnt0 | (gnt1 & ~m1_is_write);

    // consecutive m0 grants while m1 is waiting, saturating at the limit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt <= '0;
        end else if (!req1 || gnt1) begin
            run_cnt <= '0;
        end else if (gnt0 && run_cnt != RUN_MAX) begin
            run_cnt <= run_cnt + RUN_W'(1);
        end
    end

    // one-deep read return tracker; owner only moves on a read issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            rd_pend <= issue_read;
            if (issue_read) begin
                rd_owner <= gnt1;
            end
        end
    end

    assign m0_readdatavalid = rd_pend & ~rd_owner;
    assign m1_readdatavalid = rd_pend &  rd_owner;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
- Two-master arbiter for the single-port 8K x 32 instruction memory (one synchronous read/write port, byte enables, clock enable).
- Shares the memory between the processor instruction-fetch port (m0, read-only) and the code loader/debug port (m1, read/write).
- Issues at most one access per cycle with fixed m0 priority and an anti-starvation limit for m1.
- Routes each read response back to its issuing master one cycle after issue.

Parameters:
- ADDR_W, 13, word address width.
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- MAX_RUN, 8, maximum consecutive m0 grants while m1 is waiting; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- hold  in  1  freeze request (memory reset/maintenance): blocks new grants, drives mem_clken low.
- m0_address  in  ADDR_W  fetch word address.
- m0_read  in  1  fetch read request.
- m0_waitrequest  out  1  request not accepted this cycle.
- m0_readdata  out  DATA_W  fetch read data.
- m0_readdatavalid  out  1  m0_readdata valid this cycle.
- m1_address  in  ADDR_W  loader word address.
- m1_read  in  1  loader read request.
- m1_write  in  1  loader write request.
- m1_writedata  in  DATA_W  write data.
- m1_byteenable  in  BE_W  write byte lanes.
- m1_waitrequest  out  1  request not accepted this cycle.
- m1_readdata  out  DATA_W  loader read data.
- m1_readdatavalid  out  1  m1_readdata valid this cycle.
- mem_address  out  ADDR_W  to RAM address.
- mem_chipselect  out  1  RAM access strobe.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_byteenable  out  BE_W  RAM byte enables.
- mem_clken  out  1  RAM clock enable.
- mem_readdata  in  DATA_W  RAM q (valid the cycle after a read is issued).

Behaviour:
- Reset (reset_n low, asynchronous):
  - rd_pend=0, rd_owner=0, run_cnt=0.
  - m0_waitrequest=m1_waitrequest=1, mem_chipselect=0, mem_write=0, both readdatavalid=0.
- Request definitions: req0 = m0_read; req1 = m1_read | m1_write.
- m1_read and m1_write both high is illegal; the arbiter treats it as a write.
- Grant decision is combinational each cycle, with hold=0 and reset_n=1:
  - Neither requesting: no grant.
  - Only one requesting: grant that master.
  - Both requesting: grant m1 if run_cnt == MAX_RUN, else grant m0.
  - hold=1: no grant.
- Granted master sees waitrequest=0; the other sees waitrequest=1. With no grant, both waitrequests are 1.
- Memory drive:
  - mem_address, mem_writedata, mem_byteenable and mem_write are muxed from the granted master.
  - For m0 grants: mem_write=0, mem_byteenable=all ones.
  - mem_chipselect=1 only on a grant.
  - When idle, mem_address holds the m0 address and mem_byteenable is all ones.
- mem_clken = ~hold, combinational.
- run_cnt (registered, saturating at MAX_RUN):
  - Increments on an m0 grant while req1=1.
  - Clears on an m1 grant, or in any cycle req1=0.
- Read return pipeline, latency exactly 1 cycle:
  - On a granted read: rd_pend<=1 and rd_owner<=granted id, else rd_pend<=0.
  - mx_readdatavalid = rd_pend & (rd_owner==x).
  - Both mx_readdata are driven from mem_readdata unconditionally.
- Writes generate no response.
- Back-to-back grants are allowed every cycle, including alternating masters. Responses stay in issue order with no overlap.
- hold asserted the cycle after a read issue: the response is still delivered (data was latched at the issuing edge). hold only blocks new issues.
- Reset mid-read: the pending response is discarded and no readdatavalid follows.
- Read-during-write to the same address is not possible (one access per cycle); no hazard logic.

Test Plan:
- Reset released, m0_read=1 addr 0x0010 (RAM preloaded 0xDEADBEEF) -> m0_waitrequest=0 same cycle; next cycle m0_readdatavalid=1, m0_readdata=0xDEADBEEF; m1_readdatavalid=0.
- m1_write addr 0x1FFF data 0x12345678 be=4'b0011, then m1_read 0x1FFF -> write issues with mem_write=1, be=0011; read returns 0xXXXX5678 with the upper bytes unchanged from the preload.
- m0_read and m1_read held high continuously, MAX_RUN=8 -> grant pattern m0 x8, m1 x1, repeating. m1_waitrequest low on every 9th cycle; run_cnt returns to 0 after each m1 grant.
- Alternating single-cycle m0/m1 reads at addrs 0x0001/0x0002 -> readdatavalid alternates m0/m1 each cycle with the matching data and no dropped or duplicated responses.
- hold=1 for 3 cycles while both request, asserted the cycle after an m0 read issue -> the m0 response is still delivered. mem_clken=0 and both waitrequests=1 for 3 cycles, then arbitration resumes.
- reset_n pulsed low the cycle after an m1 read issue -> m1_readdatavalid never asserts. All outputs reach reset values asynchronously.
